// File: rtl/me_sad_search.sv
// Full-search 16x16 SAD motion estimator over an 8x8 offset range.
// Accumulates all candidates row-by-row as the window streams in, then scans for the minimum.
module me_sad_search #(
   parameter int BLK   = 16,
   parameter int RANGE = 8,
   parameter int PW    = 8,
   parameter int SADW  = 16
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           cur_wr_en,
   input  logic [$clog2(BLK)-1:0]         cur_wr_row,
   input  logic [BLK*PW-1:0]              cur_wr_data,
   input  logic                           next_block,
   input  logic                           ref_valid,
   input  logic [(BLK+RANGE-1)*PW-1:0]    ref_row,
   output logic                           busy,
   output logic                           mv_valid,
   output logic [$clog2(RANGE)-1:0]       mv_x,
   output logic [$clog2(RANGE)-1:0]       mv_y,
   output logic [SADW-1:0]                min_sad
);

   localparam int WIN = BLK + RANGE - 1;
   localparam int RW  = $clog2(WIN);
   localparam int CW  = $clog2(BLK);
   localparam int MW  = $clog2(RANGE);
   localparam int SW  = $clog2(RANGE * RANGE);
   localparam int DW  = PW + CW;

   typedef enum logic [1:0] {IDLE, ACCUM, COMPARE, DONE} state_t;

   state_t state, state_nx;

   logic [BLK*PW-1:0] cur_mem [BLK];
   logic [SADW-1:0]   acc [RANGE][RANGE];
   logic [DW-1:0]     rsum [RANGE][RANGE];
   logic [RW-1:0]     row;
   logic [SW-1:0]     scan;
   logic [SADW-1:0]   best;
   logic [SW-1:0]     best_idx;
   logic [SADW-1:0]   cand;
   logic              accept;
   logic              last_row;

   assign busy     = (state != IDLE);
   assign accept   = (state == ACCUM) && ref_valid && !next_block;
   assign last_row = accept && (row == RW'(WIN - 1));
   assign cand     = acc[scan[SW-1:MW]][scan[MW-1:0]];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (next_block) begin
         state_nx = ACCUM;
      end else begin
         unique case (state)
            IDLE:    state_nx = IDLE;
            ACCUM:   if (last_row) state_nx = COMPARE;
            COMPARE: if (scan == SW'(RANGE * RANGE - 1)) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
         endcase
      end
   end

   // Window row r contributes to candidate row v through block row r-v.
   always_comb begin
      int              ri;
      logic [CW-1:0]   ridx;
      logic [PW-1:0]   a;
      logic [PW-1:0]   b;
      logic [PW-1:0]   d;
      ri   = 0;
      ridx = '0;
      a    = '0;
      b    = '0;
      d    = '0;
      for (int v = 0; v < RANGE; v++) begin
         ri   = int'(row) - v;
         ridx = CW'(ri);
         for (int h = 0; h < RANGE; h++) begin
            rsum[v][h] = '0;
            if (ri >= 0 && ri < BLK) begin
               for (int k = 0; k < BLK; k++) begin
                  a = cur_mem[ridx][PW*k +: PW];
                  b = ref_row[PW*(h+k) +: PW];
                  d = (a > b) ? a - b : b - a;
                  rsum[v][h] = rsum[v][h] + DW'(d);
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int y = 0; y < BLK; y++) cur_mem[y] <= '0;
         for (int v = 0; v < RANGE; v++)
            for (int h = 0; h < RANGE; h++) acc[v][h] <= '0;
         row      <= '0;
         scan     <= '0;
         best     <= '0;
         best_idx <= '0;
         mv_valid <= 1'b0;
         mv_x     <= '0;
         mv_y     <= '0;
         min_sad  <= '0;
      end else begin
         mv_valid <= 1'b0;
         if (state == IDLE && cur_wr_en)
            cur_mem[cur_wr_row] <= cur_wr_data;
         if (next_block) begin
            for (int v = 0; v < RANGE; v++)
               for (int h = 0; h < RANGE; h++) acc[v][h] <= '0;
            row <= '0;
         end else if (accept) begin
            for (int v = 0; v < RANGE; v++)
               for (int h = 0; h < RANGE; h++)
                  acc[v][h] <= acc[v][h] + SADW'(rsum[v][h]);
            row <= row + 1'b1;
         end
         // Strict less-than keeps the lowest raster index on ties.
         if (state == COMPARE) begin
            scan <= scan + 1'b1;
            if (scan == '0 || cand < best) begin
               best     <= cand;
               best_idx <= scan;
            end
         end else begin
            scan <= '0;
         end
         if (state == DONE) begin
            mv_valid <= 1'b1;
            mv_x     <= best_idx[MW-1:0];
            mv_y     <= best_idx[SW-1:MW];
            min_sad  <= best;
         end
      end
   end

endmodule
